// File: rtl/vga_timing_generator.sv
// Free-running raster timing generator (640x480@60 by default) on the pixel clock.
// Produces sync pulses, pixel position, display enable, per-frame strobes and a frame counter.
module vga_timing_generator #(
  parameter int H_VISIBLE   = 640,
  parameter int H_FRONT     = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BACK      = 48,
  parameter int V_VISIBLE   = 480,
  parameter int V_FRONT     = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BACK      = 33,
  parameter bit SYNC_ACTIVE = 1'b0
) (
  input  logic        vga_clock,
  input  logic        reset,
  output logic        hsync,
  output logic        vsync,
  output logic [31:0] column,
  output logic [31:0] row,
  output logic        display_enable,
  output logic        frame_start,
  output logic        blank_start,
  output logic [7:0]  frame_count
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [31:0] H_LAST     = 32'(H_TOTAL - 1);
  localparam logic [31:0] V_LAST     = 32'(V_TOTAL - 1);
  localparam logic [31:0] H_VIS      = 32'(H_VISIBLE);
  localparam logic [31:0] V_VIS      = 32'(V_VISIBLE);
  localparam logic [31:0] H_SYNC_BEG = 32'(H_VISIBLE + H_FRONT);
  localparam logic [31:0] H_SYNC_END = 32'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [31:0] V_SYNC_BEG = 32'(V_VISIBLE + V_FRONT);
  localparam logic [31:0] V_SYNC_END = 32'(V_VISIBLE + V_FRONT + V_SYNC);

  logic [31:0] h_cnt;
  logic [31:0] v_cnt;
  logic        frame_armed;
  logic        h_last;
  logic        v_last;
  logic        at_origin;
  logic        at_blank;
  logic        in_hsync;
  logic        in_vsync;
  logic        visible;

  always_comb begin
    h_last    = (h_cnt == H_LAST);
    v_last    = (v_cnt == V_LAST);
    at_origin = (h_cnt == '0) && (v_cnt == '0);
    at_blank  = (h_cnt == '0) && (v_cnt == V_VIS);
    in_hsync  = (h_cnt >= H_SYNC_BEG) && (h_cnt < H_SYNC_END);
    in_vsync  = (v_cnt >= V_SYNC_BEG) && (v_cnt < V_SYNC_END);
    visible   = (h_cnt < H_VIS) && (v_cnt < V_VIS);
  end

  always_ff @(posedge vga_clock) begin
    if (!reset) begin
      h_cnt          <= '0;
      v_cnt          <= '0;
      column         <= '0;
      row            <= '0;
      display_enable <= 1'b0;
      frame_start    <= 1'b0;
      blank_start    <= 1'b0;
      hsync          <= ~SYNC_ACTIVE;
      vsync          <= ~SYNC_ACTIVE;
      frame_count    <= '0;
      frame_armed    <= 1'b0;
    end else begin
      if (h_last) begin
        h_cnt <= '0;
        v_cnt <= v_last ? '0 : v_cnt + 32'd1;
      end else begin
        h_cnt <= h_cnt + 32'd1;
      end

      column         <= h_cnt;
      row            <= v_cnt;
      display_enable <= visible;
      frame_start    <= at_origin;
      blank_start    <= at_blank;
      hsync          <= in_hsync ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      vsync          <= in_vsync ? SYNC_ACTIVE : ~SYNC_ACTIVE;

      // The origin seen right after reset starts frame 0 and is not a completed frame.
      if (at_origin) begin
        frame_armed <= 1'b1;
        if (frame_armed) frame_count <= frame_count + 8'd1;
      end
    end
  end

endmodule

// File: doc/vga_timing_generator.md
Name: vga_timing_generator

Overview:
- Free-running 640x480@60 raster timing generator, clocked by the 25 MHz pixel clock.
- Drives hsync/vsync to the VGA connector.
- Feeds the downstream VGA logic stage with the current pixel position (row, column) and display_enable.
- Issues per-frame strobes for game logic: frame_start and blank_start (the safe update window), plus a frame counter.

Parameters:
- H_VISIBLE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (clocks)
- H_SYNC, 96, horizontal sync width (clocks)
- H_BACK, 48, horizontal back porch (clocks)
- V_VISIBLE, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BACK, 33, vertical back porch (lines)
- SYNC_ACTIVE, 0, sync pulse asserted level (0 = active-low)

Ports:
- vga_clock  input  1  pixel clock; all logic on rising edge
- reset  input  1  synchronous, active-low reset
- hsync  output  1  horizontal sync
- vsync  output  1  vertical sync
- column  output  int (32)  horizontal position of current pixel, 0..H_TOTAL-1
- row  output  int (32)  vertical position of current pixel, 0..V_TOTAL-1
- display_enable  output  1  high when the current pixel is in the visible area
- frame_start  output  1  one-cycle pulse at pixel (row 0, column 0)
- blank_start  output  1  one-cycle pulse at (row V_VISIBLE, column 0)
- frame_count  output  8  frames completed since reset, wraps

Behaviour:
- Derived constants: H_TOTAL = sum of the four H_ parameters (800); V_TOTAL = sum of the four V_ parameters (525).
- Internal counters h_cnt (0..H_TOTAL-1) and v_cnt (0..V_TOTAL-1), both registered.
- Each clock with reset=1:
  - h_cnt increments.
  - At h_cnt = H_TOTAL-1, h_cnt wraps to 0 and v_cnt increments.
  - At v_cnt = V_TOTAL-1 together with h_cnt = H_TOTAL-1, v_cnt wraps to 0.
- All outputs are registered and decoded from the counter values of the previous cycle (1-cycle latency). All outputs are mutually aligned, so every output in a given cycle describes the same pixel.
- Decode of position (h, v):
  - column = h; row = v.
  - display_enable = (h < H_VISIBLE) && (v < V_VISIBLE).
  - hsync = SYNC_ACTIVE when H_VISIBLE+H_FRONT <= h < H_VISIBLE+H_FRONT+H_SYNC (656..751), else ~SYNC_ACTIVE.
  - vsync = SYNC_ACTIVE when V_VISIBLE+V_FRONT <= v < V_VISIBLE+V_FRONT+V_SYNC (490..491, all 800 clocks of each line), else ~SYNC_ACTIVE.
  - frame_start = (h == 0 && v == 0).
  - blank_start = (h == 0 && v == V_VISIBLE).
- frame_count increments by 1 on the same cycle frame_start is output high. It wraps 255 -> 0.
  - The frame in progress at reset release does not count.
  - Therefore frame_count reads 0 during frame 0 and 1 from the start of frame 1.
- Reset (reset=0 sampled on a rising edge), taking effect on that edge:
  - h_cnt = 0, v_cnt = 0, column = 0, row = 0, frame_count = 0.
  - display_enable = 0, frame_start = 0, blank_start = 0.
  - hsync = vsync = ~SYNC_ACTIVE.
- Reset is honoured at any point mid-line or mid-frame, with no partial-frame state retained.
- First edge with reset=1: outputs decode position (0,0), i.e. display_enable=1, frame_start=1, column=0, row=0. h_cnt becomes 1.
- No other inputs; the block never stalls.
- Frame period is exactly H_TOTAL*V_TOTAL = 420000 clocks.

Test Plan:
- Reset: hold reset=0 for 5 clocks -> hsync=1, vsync=1, display_enable=0, row=0, column=0, frame_count=0, both strobes 0. Release -> next edge: frame_start=1, display_enable=1, column=0.
- Line timing: from frame_start cycle, count clocks.
  - display_enable high for exactly 640 clocks, then low for 160.
  - hsync low exactly on clocks 656..751 of each line.
  - column returns to 0 on clock 800, with row incrementing.
- Frame timing:
  - frame_start pulses exactly 420000 clocks apart.
  - blank_start pulses 384000 clocks after frame_start.
  - vsync low for exactly 1600 consecutive clocks starting at row 490, column 0.
  - display_enable is never high for row >= 480.
- Reset mid-frame: assert reset=0 at row 300, column 417 for 1 clock -> outputs return to reset values on that edge; next edge outputs (0,0) with frame_start=1; frame_count=0.
- Counter wrap: run 256 frames after reset -> frame_count reads 255 at the start of frame 255, and at the start of frame 256 returns to 0 in the same cycle frame_start is high.
- Parameter override: H_VISIBLE=8, H_FRONT=1, H_SYNC=2, H_BACK=1, V_VISIBLE=4, V_FRONT=1, V_SYNC=1, V_BACK=1 -> line is 12 clocks, frame is 84 clocks, hsync low at columns 9..10, vsync low on row 5.
